flow_counter_rmw: RTL and testbench

FLOW_COUNTER_RMW -- requirements
Module: flow_counter_rmw

---
 rtl/flow_counter_rmw_pkg.sv | 10 +
 rtl/tdp_bram.sv | 30 +++
 rtl/flow_counter_rmw.sv | 146 ++++++++++++++
 tb/tb_flow_counter_rmw.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/flow_counter_rmw_pkg.sv
// Shared types for the flow counter read-modify-write block.
package flow_counter_rmw_pkg;

    // Which requester wins the next contested cycle.
    typedef enum logic {
        PRI_UPD = 1'b0,
        PRI_RD  = 1'b1
    } rr_e;

endpackage

// File: rtl/tdp_bram.sv
// True-dual-port block RAM: port A registered read, port B write.
module tdp_bram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 18,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  ena,
    input  logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout_raw;

    // Words are stored XORed with INIT_VAL so power-up-zero storage reads back as INIT_VAL.
    always_ff @(posedge clk) begin
        if (ena) dout_raw <= mem[addra];
    end

    always_ff @(posedge clk) begin
        if (web) mem[addrb] <= dinb ^ INIT_VAL;
    end

    assign douta = dout_raw ^ INIT_VAL;

endmodule

// File: rtl/flow_counter_rmw.sv
// Per-flow counter bank: pipelined RAM read-modify-write with forwarding, queries and bulk clear.
module flow_counter_rmw
    import flow_counter_rmw_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int INC_WIDTH  = 16,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic [INC_WIDTH-1:0]  upd_inc,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  sat_pulse
);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

    localparam int STAGES = 3;
    localparam int S1 = 0, S2 = 1, S3 = 2;

    state_e                state;
    rr_e                   rr;
    logic                  ready_en;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [STAGES-1:0]     vld_pipe;

    logic                  s1_upd, s2_upd;
    logic [ADDR_WIDTH-1:0] s1_addr, s2_addr, s3_addr;
    logic [INC_WIDTH-1:0]  s1_inc;
    logic [DATA_WIDTH-1:0] s2_data, s3_data, ram_dout;

    logic                  can_accept, upd_fire, rd_fire, acc, enter_clear, clr_mode;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] base, result;
    logic [DATA_WIDTH:0]   sum;
    logic                  s1_sat;

    // The loser of a contested cycle sees ready low; uncontested requests always win.
    assign can_accept = ready_en && (state == IDLE);
    assign upd_ready  = can_accept && !(rd_valid && rr == PRI_RD);
    assign rd_ready   = can_accept && !(upd_valid && rr == PRI_UPD);
    assign upd_fire   = upd_valid && upd_ready;
    assign rd_fire    = rd_valid && rd_ready;
    assign acc        = upd_fire || rd_fire;
    assign acc_addr   = upd_fire ? upd_addr : rd_addr;
    assign busy       = (state != IDLE);
    assign clr_mode   = (state == CLEAR);
    assign enter_clear = (state == DRAIN) && !vld_pipe[S1] && !vld_pipe[S2];

    // S2 is the newest uncommitted value; S3 covers the read-first RAM collision one cycle later.
    always_comb begin
        base = ram_dout;
        if (vld_pipe[S2] && s2_upd && s2_addr == s1_addr) base = s2_data;
        else if (vld_pipe[S3] && s3_addr == s1_addr)      base = s3_data;
        sum    = {1'b0, base} + (DATA_WIDTH+1)'(s1_inc);
        s1_sat = (SATURATE != 0) && sum[DATA_WIDTH];
        result = s1_sat ? '1 : sum[DATA_WIDTH-1:0];
    end

    tdp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_VAL   ('0)
    ) u_ram (
        .clk   (clk),
        .ena   (acc),
        .addra (acc_addr),
        .douta (ram_dout),
        .web   (clr_mode || (vld_pipe[S2] && s2_upd)),
        .addrb (clr_mode ? clr_cnt : s2_addr),
        .dinb  (clr_mode ? '0 : s2_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            s1_upd    <= 1'b0;
            s1_addr   <= '0;
            s1_inc    <= '0;
            s2_upd    <= 1'b0;
            s2_addr   <= '0;
            s2_data   <= '0;
            s3_addr   <= '0;
            s3_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            sat_pulse <= 1'b0;
        end else begin
            vld_pipe[S1] <= acc;
            s1_upd       <= upd_fire;
            s1_addr      <= acc_addr;
            s1_inc       <= upd_inc;
            vld_pipe[S2] <= vld_pipe[S1];
            s2_upd       <= s1_upd;
            s2_addr      <= s1_addr;
            s2_data      <= result;
            vld_pipe[S3] <= vld_pipe[S2] && s2_upd && !enter_clear;
            s3_addr      <= s2_addr;
            s3_data      <= s2_data;
            rsp_valid    <= vld_pipe[S1] && !s1_upd;
            sat_pulse    <= vld_pipe[S1] && s1_upd && s1_sat;
            if (vld_pipe[S1] && !s1_upd) begin
                rsp_addr <= s1_addr;
                rsp_data <= base;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= PRI_UPD;
            ready_en <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (can_accept && upd_valid && rd_valid)
                rr <= (rr == PRI_UPD) ? PRI_RD : PRI_UPD;
            case (state)
                IDLE:  if (clr_req) state <= DRAIN;
                DRAIN: if (enter_clear) begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flow_counter_rmw.sv
// Directed bench: saturating and wrapping instances driven by the same stimulus.
module tb_flow_counter_rmw;

    localparam int DW = 8, AW = 4, IW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          upd_valid, rd_valid, clr_req;
    logic [AW-1:0] upd_addr, rd_addr;
    logic [IW-1:0] upd_inc;

    logic          upd_ready, rd_ready, rsp_valid, busy, sat_pulse;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          upd_ready_w, rd_ready_w, rsp_valid_w, busy_w, sat_pulse_w;
    logic [AW-1:0] rsp_addr_w;
    logic [DW-1:0] rsp_data_w;

    int checks = 0, errors = 0;
    int sat_cnt = 0, satw_cnt = 0;
    logic [AW+DW-1:0] rsp_q[$], rspw_q[$];

    always #5 clk = ~clk;

    flow_counter_rmw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INC_WIDTH(IW), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_addr(upd_addr), .upd_inc(upd_inc), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .clr_req(clr_req), .busy(busy), .sat_pulse(sat_pulse));

    flow_counter_rmw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INC_WIDTH(IW), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready_w),
        .upd_addr(upd_addr), .upd_inc(upd_inc), .rd_valid(rd_valid), .rd_ready(rd_ready_w),
        .rd_addr(rd_addr), .rsp_valid(rsp_valid_w), .rsp_addr(rsp_addr_w), .rsp_data(rsp_data_w),
        .clr_req(clr_req), .busy(busy_w), .sat_pulse(sat_pulse_w));

    always @(negedge clk) begin
        if (rsp_valid)   rsp_q.push_back({rsp_addr, rsp_data});
        if (rsp_valid_w) rspw_q.push_back({rsp_addr_w, rsp_data_w});
        if (sat_pulse)   sat_cnt++;
        if (sat_pulse_w) satw_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_burst(input logic [AW-1:0] a, input logic [IW-1:0] inc, input int n);
        upd_valid = 1'b1; upd_addr = a; upd_inc = inc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("upd_ready", upd_ready, 1);
            step();
        end
        upd_valid = 1'b0;
    endtask

    task automatic query(input logic [AW-1:0] a);
        rd_valid = 1'b1; rd_addr = a;
        step();
        rd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input bit wrap, input logic [AW+DW-1:0] exp);
        logic [AW+DW-1:0] got;
        for (int i = 0; i < 10 && (wrap ? rspw_q.size() : rsp_q.size()) == 0; i++) step();
        if ((wrap ? rspw_q.size() : rsp_q.size()) == 0) begin
            chk({tag, " rsp timeout"}, 0, 1);
        end else begin
            got = wrap ? rspw_q.pop_front() : rsp_q.pop_front();
            chk(tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) step();
        chk({tag, " busy timeout"}, busy, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " sat"},  {upd_ready, rd_ready, busy, rsp_valid, sat_pulse, rsp_addr, rsp_data}, 0);
        chk({tag, " wrap"}, {upd_ready_w, rd_ready_w, busy_w, rsp_valid_w, sat_pulse_w, rsp_addr_w, rsp_data_w}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc;
        upd_valid = 0; rd_valid = 0; clr_req = 0;
        upd_addr = '0; rd_addr = '0; upd_inc = '0;

        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        chk("ready after reset", {upd_ready, rd_ready}, 2'b11);

        clr_req = 1'b1; step(); clr_req = 1'b0;
        chk("busy after clr", busy, 1);
        wait_idle("init clear");
        rsp_q.delete(); rspw_q.delete();

        // six back-to-back increments, query latency exactly two cycles
        upd_burst(4'd3, 4'd1, 6);
        rd_valid = 1'b1; rd_addr = 4'd3;
        step();
        rd_valid = 1'b0;
        chk("rsp early", rsp_valid, 0);
        step();
        chk("rsp at T+2", rsp_valid, 1);
        chk("rsp addr3", rsp_addr, 3);
        chk("rsp data3", rsp_data, 6);
        step();
        rsp_q.delete(); rspw_q.delete();

        // contested stream alternates grants, starting with update
        upd_valid = 1'b1; upd_addr = 4'd5; upd_inc = 4'd2;
        rd_valid = 1'b1; rd_addr = 4'd5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("arb upd", upd_ready, (i % 2) == 0);
            chk("arb rd",  rd_ready,  (i % 2) == 1);
            step();
        end
        upd_valid = 1'b0; rd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) get_rsp("interleave", 0, {4'd5, 8'(2 * k)});
        rsp_q.delete(); rspw_q.delete();

        // saturate vs wrap
        sat_cnt = 0; satw_cnt = 0;
        upd_burst(4'd1, 4'd15, 16);
        upd_burst(4'd1, 4'd10, 1);
        repeat (4) step();
        chk("no sat at 250", sat_cnt, 0);
        upd_burst(4'd1, 4'd15, 1);
        repeat (4) step();
        chk("sat pulse count", sat_cnt, 1);
        chk("wrap no pulse", satw_cnt, 0);
        rsp_q.delete(); rspw_q.delete();
        query(4'd1);
        get_rsp("sat value", 0, {4'd1, 8'd255});
        get_rsp("wrap value", 1, {4'd1, 8'd9});

        // clear with updates in flight, requesters held high while busy
        upd_valid = 1'b1; upd_addr = 4'd9; upd_inc = 4'd3;
        step(); step();
        clr_req = 1'b1; step(); clr_req = 1'b0;
        rd_valid = 1'b1; rd_addr = 4'd9;
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
            chk("ready while busy", {upd_ready, rd_ready}, 0);
        end
        upd_valid = 1'b0; rd_valid = 1'b0;
        chk("busy cycles", bc, 19);
        @(posedge clk); #1;
        rsp_q.delete(); rspw_q.delete();
        rd_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k);
            step();
        end
        rd_valid = 1'b0;
        for (int k = 0; k < 16; k++) get_rsp("cleared", 0, {4'(k), 8'd0});
        rsp_q.delete(); rspw_q.delete();

        // reset in the middle of a clear
        upd_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            upd_addr = 4'(k); upd_inc = 4'((k % 15) + 1);
            step();
        end
        upd_valid = 1'b0;
        repeat (4) step();
        clr_req = 1'b1; step(); clr_req = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("mid-clear reset");
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        chk("ready after reset2", {upd_ready, rd_ready}, 2'b11);
        rsp_q.delete(); rspw_q.delete();
        rd_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k);
            step();
        end
        rd_valid = 1'b0;
        for (int k = 0; k < 16; k++)
            get_rsp("partial clear", 0, {4'(k), (k < 7) ? 8'd0 : 8'((k % 15) + 1)});

        // arbiter pointer back on update after reset
        upd_valid = 1'b1; upd_addr = 4'd2; upd_inc = 4'd1;
        rd_valid = 1'b1; rd_addr = 4'd2;
        @(negedge clk);
        chk("arb after reset", {upd_ready, rd_ready}, 2'b10);
        step();
        upd_valid = 1'b0; rd_valid = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
